// File: rtl/spike_logger_if.sv
// Event stream from spike_logger to its consumer: valid/ready handshake,
// timestamp payload and FIFO occupancy.
interface spike_logger_if #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned TS_W  = 8
);
  localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

  logic             evt_valid;
  logic             evt_ready;
  logic [TS_W-1:0]  evt_data;
  logic [LVL_W-1:0] level;

  modport master (output evt_valid, output evt_data, output level, input evt_ready);
  modport slave  (input evt_valid, input evt_data, input level, output evt_ready);
endinterface

// File: rtl/spike_logger.sv
// Timestamps spikes into a small event FIFO with sticky overflow, and
// reports the spike count of each completed rate window.
module spike_logger #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TS_W    = 8,
  parameter int unsigned WIN_LEN = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  spike,
  input  logic                  enable,
  input  logic                  clear_ovf,
  spike_logger_if.master        evt,
  output logic                  overflow,
  output logic [7:0]            rate
);
  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned LVL_W  = PTR_W + 1;
  localparam int unsigned WIN_W  = $clog2(WIN_LEN);
  localparam int unsigned RATE_W = 8;

  logic [TS_W-1:0]   ts_q;
  logic [WIN_W-1:0]  win_q;
  logic [RATE_W-1:0] acc_q;
  logic [RATE_W-1:0] rate_q;
  logic [PTR_W-1:0]  wr_ptr_q;
  logic [PTR_W-1:0]  rd_ptr_q;
  logic [LVL_W-1:0]  level_q;
  logic              valid_q;
  logic [TS_W-1:0]   data_q;
  logic              ovf_q;
  logic [TS_W-1:0]   mem [DEPTH];

  logic              push_c;
  logic              pop_c;
  logic              full_c;
  logic              push_ok_c;
  logic              drop_c;
  logic [PTR_W-1:0]  rd_next_c;
  logic [LVL_W-1:0]  level_n_c;
  logic [TS_W-1:0]   head_n_c;
  logic              win_end_c;
  logic [RATE_W-1:0] acc_sum_c;

  // FIFO control: a push on a full FIFO only lands if a pop frees the slot
  always_comb begin
    push_c    = spike & enable;
    pop_c     = valid_q & evt.evt_ready;
    full_c    = (level_q == LVL_W'(DEPTH));
    push_ok_c = push_c & (~full_c | pop_c);
    drop_c    = push_c & full_c & ~pop_c;
    rd_next_c = rd_ptr_q + PTR_W'(1);

    level_n_c = level_q;
    case ({push_ok_c, pop_c})
      2'b10:   level_n_c = level_q + LVL_W'(1);
      2'b01:   level_n_c = level_q - LVL_W'(1);
      default: level_n_c = level_q;
    endcase

    // Registered head: bypass the incoming timestamp when it becomes the head
    head_n_c = data_q;
    if (pop_c) begin
      if (level_q == LVL_W'(1)) head_n_c = ts_q;
      else                      head_n_c = mem[rd_next_c];
    end else if (level_q == '0 && push_ok_c) begin
      head_n_c = ts_q;
    end
  end

  // Rate window arithmetic; accumulator saturates at 255
  always_comb begin
    win_end_c = (win_q == WIN_W'(WIN_LEN - 1));
    acc_sum_c = (acc_q == '1) ? acc_q : acc_q + RATE_W'(spike);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ts_q     <= '0;
      win_q    <= '0;
      acc_q    <= '0;
      rate_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      valid_q  <= 1'b0;
      data_q   <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (enable) begin
        ts_q <= ts_q + TS_W'(1);
        if (win_end_c) begin
          win_q  <= '0;
          rate_q <= acc_sum_c;
          acc_q  <= '0;
        end else begin
          win_q <= win_q + WIN_W'(1);
          acc_q <= acc_sum_c;
        end
      end
      if (push_ok_c) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_c)     rd_ptr_q <= rd_next_c;
      level_q <= level_n_c;
      valid_q <= (level_n_c != '0);
      data_q  <= head_n_c;
      if (drop_c)         ovf_q <= 1'b1;
      else if (clear_ovf) ovf_q <= 1'b0;
    end
  end

  // Storage is never observable while empty, so it carries no reset
  always_ff @(posedge clk) begin
    if (push_ok_c) mem[wr_ptr_q] <= ts_q;
  end

  assign evt.evt_valid = valid_q;
  assign evt.evt_data  = data_q;
  assign evt.level     = level_q;
  assign overflow      = ovf_q;
  assign rate          = rate_q;
endmodule

// File: tb/tb_spike_logger.sv
// Directed bench for spike_logger: FIFO ordering, overflow, timestamp wrap,
// rate windows and asynchronous reset.
module tb_spike_logger;
  logic       clk;
  logic       reset;
  logic       spike;
  logic       enable;
  logic       clear_ovf;
  logic       overflow;
  logic [7:0] rate;
  int         n_checks;
  int         n_errors;

  spike_logger_if #(.DEPTH(4), .TS_W(8)) bus ();

  spike_logger #(.DEPTH(4), .TS_W(8), .WIN_LEN(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .spike     (spike),
    .enable    (enable),
    .clear_ovf (clear_ovf),
    .evt       (bus.master),
    .overflow  (overflow),
    .rate      (rate)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Inputs change just after a falling edge; outputs are sampled there too
  task automatic step(input logic s, input logic r);
    spike         = s;
    bus.evt_ready = r;
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset         = 1'b0;
    spike         = 1'b0;
    enable        = 1'b0;
    clear_ovf     = 1'b0;
    bus.evt_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset  = 1'b1;
    enable = 1'b1;
  endtask

  initial begin
    n_checks      = 0;
    n_errors      = 0;
    reset         = 1'b0;
    spike         = 1'b0;
    enable        = 1'b0;
    clear_ovf     = 1'b0;
    bus.evt_ready = 1'b0;
    @(negedge clk);
    check("rst_valid", 32'(bus.evt_valid), 0);
    check("rst_level", 32'(bus.level), 0);
    check("rst_data", 32'(bus.evt_data), 0);
    check("rst_ovf", 32'(overflow), 0);
    check("rst_rate", 32'(rate), 0);

    // Spikes on cycles 3 and 5, then drain
    do_reset();
    for (int c = 0; c < 6; c++) begin
      step(c == 3 || c == 5, 1'b0);
      if (c == 2) check("pre_push_valid", 32'(bus.evt_valid), 0);
      if (c == 3) begin
        check("push_lat_valid", 32'(bus.evt_valid), 1);
        check("push_lat_data", 32'(bus.evt_data), 3);
      end
    end
    check("two_level", 32'(bus.level), 2);
    check("two_head", 32'(bus.evt_data), 3);
    step(1'b0, 1'b1);
    check("pop1_data", 32'(bus.evt_data), 5);
    check("pop1_level", 32'(bus.level), 1);
    step(1'b0, 1'b1);
    check("pop2_valid", 32'(bus.evt_valid), 0);
    check("pop2_level", 32'(bus.level), 0);

    // Overflow, clear, drop-beats-clear, full push+pop
    do_reset();
    for (int c = 0; c < 5; c++) step(1'b1, 1'b0);
    check("full_level", 32'(bus.level), 4);
    check("full_ovf", 32'(overflow), 1);
    check("full_head", 32'(bus.evt_data), 0);
    clear_ovf = 1'b1;
    step(1'b0, 1'b0);
    check("clr_ovf", 32'(overflow), 0);
    step(1'b1, 1'b0);
    check("drop_wins", 32'(overflow), 1);
    step(1'b0, 1'b0);
    clear_ovf = 1'b0;
    check("clr_ovf2", 32'(overflow), 0);
    step(1'b1, 1'b1);
    check("fpp_level", 32'(bus.level), 4);
    check("fpp_ovf", 32'(overflow), 0);
    begin
      logic [7:0] exp_q [4];
      exp_q = '{8'd1, 8'd2, 8'd3, 8'd8};
      for (int i = 0; i < 4; i++) begin
        check("drain_data", 32'(bus.evt_data), 32'(exp_q[i]));
        step(1'b0, 1'b1);
      end
    end
    check("drain_valid", 32'(bus.evt_valid), 0);

    // Timestamp wrap: spike on cycle 257 logs ts 1
    do_reset();
    for (int c = 0; c < 258; c++) step(c == 257, 1'b0);
    check("wrap_level", 32'(bus.level), 1);
    check("wrap_data", 32'(bus.evt_data), 1);

    // Rate windows, including an enable gap that stretches the window
    do_reset();
    for (int c = 0; c < 16; c++) begin
      if (c == 15) check("win1_hold", 32'(rate), 0);
      step(1'b1, 1'b0);
    end
    check("win1_rate", 32'(rate), 16);
    for (int c = 16; c < 32; c++) begin
      if (c == 31) check("win2_hold", 32'(rate), 16);
      step(1'b0, 1'b0);
    end
    check("win2_rate", 32'(rate), 0);
    for (int c = 0; c < 5; c++) step(1'b1, 1'b0);
    enable = 1'b0;
    for (int c = 0; c < 10; c++) step(1'b1, 1'b0);
    enable = 1'b1;
    for (int c = 0; c < 10; c++) step(1'b0, 1'b0);
    check("win3_delayed", 32'(rate), 0);
    step(1'b1, 1'b0);
    check("win3_rate", 32'(rate), 6);

    // Asynchronous reset with three queued events
    do_reset();
    for (int c = 0; c < 16; c++) step(1'b1, 1'b0);
    step(1'b0, 1'b1);
    check("pre_rst_level", 32'(bus.level), 3);
    check("pre_rst_rate", 32'(rate), 16);
    check("pre_rst_ovf", 32'(overflow), 1);
    bus.evt_ready = 1'b0;
    #2 reset = 1'b0;
    #1;
    check("arst_valid", 32'(bus.evt_valid), 0);
    check("arst_level", 32'(bus.level), 0);
    check("arst_rate", 32'(rate), 0);
    check("arst_ovf", 32'(overflow), 0);
    check("arst_data", 32'(bus.evt_data), 0);
    @(negedge clk);
    reset = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
